// File: rtl/rx_lane_router.sv
// Routes N parallel ADC sample lanes onto NUMBER_OF_DAC DAC buses, each selecting zero,
// passthrough, saturating gain-scaled or ramp-test data; config is double-buffered and applied on a beat.
module rx_lane_router #(
  parameter int unsigned NUMBER_OF_LINE = 8,
  parameter int unsigned SAMPLE_WIDTH   = 16,
  parameter int unsigned DROP_LSB       = 2,
  parameter int unsigned NUMBER_OF_DAC  = 3,
  parameter int unsigned GAIN_WIDTH     = 8
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0]           adc_data,
  input  logic                                             adc_valid,
  input  logic [2*NUMBER_OF_DAC-1:0]                       cfg_sel,
  input  logic [GAIN_WIDTH*NUMBER_OF_DAC-1:0]              cfg_gain,
  input  logic                                             cfg_update,
  output logic                                             cfg_ack,
  output logic [SAMPLE_WIDTH*NUMBER_OF_LINE*NUMBER_OF_DAC-1:0] dac_data,
  output logic                                             dac_valid,
  output logic [NUMBER_OF_DAC-1:0]                         sat_flag,
  input  logic                                             sat_clear
);

  localparam int unsigned N   = NUMBER_OF_LINE;
  localparam int unsigned SW  = SAMPLE_WIDTH;
  localparam int unsigned D   = NUMBER_OF_DAC;
  localparam int unsigned GW  = GAIN_WIDTH;
  localparam int unsigned W_T = SW - DROP_LSB;
  localparam int unsigned W_P = W_T + GW + 1;
  localparam int unsigned W_Q = W_P + DROP_LSB;

  localparam logic [GW-1:0]         GAIN_UNITY = {1'b1, {(GW-1){1'b0}}};
  localparam logic signed [W_Q-1:0] SAT_MAX    = {{(W_Q-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [W_Q-1:0] SAT_MIN    = {{(W_Q-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {SEL_ZERO = 2'b00, SEL_PASS = 2'b01, SEL_SCALE = 2'b10, SEL_RAMP = 2'b11} sel_e;
  typedef enum logic {IDLE, PENDING} cfg_state_e;

  cfg_state_e        state_q;
  logic [2*D-1:0]    pend_sel_q, act_sel_q, eff_sel;
  logic [GW*D-1:0]   pend_gain_q, act_gain_q, eff_gain;
  logic              apply;
  logic [SW-1:0]     ramp_q    [D];
  logic [SW-1:0]     ramp_base [D];
  logic [SW-1:0]     ramp_next [D];

  logic              v1_q;
  logic [SW-1:0]     lane1_q   [N];
  sel_e              sel1_q    [D];
  logic [GW-1:0]     gain1_q   [D];
  logic [SW-1:0]     ramp1_q   [D][N];

  logic signed [W_T-1:0] trunc_d [N];
  logic signed [W_P-1:0] prod_d  [D][N];

  logic              v2_q;
  logic [SW-1:0]     lane2_q   [N];
  sel_e              sel2_q    [D];
  logic [SW-1:0]     ramp2_q   [D][N];
  logic signed [W_P-1:0] prod2_q [D][N];

  logic signed [W_Q-1:0] scaled_d [D][N];
  logic [SW*N*D-1:0] out_d;
  logic [D-1:0]      clip_d;

  // The apply beat itself already uses the new config, so S1 sees the effective (not yet active) values.
  assign apply = (state_q == PENDING) && adc_valid;

  always_comb begin
    eff_sel  = act_sel_q;
    eff_gain = act_gain_q;
    if (apply) begin
      eff_sel  = cfg_update ? cfg_sel  : pend_sel_q;
      eff_gain = cfg_update ? cfg_gain : pend_gain_q;
    end
    for (int unsigned d = 0; d < D; d++) begin
      ramp_base[d] = apply ? '0 : ramp_q[d];
      ramp_next[d] = (adc_valid && sel_e'(eff_sel[2*d +: 2]) == SEL_RAMP)
                     ? ramp_base[d] + SW'(N) : ramp_base[d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_sel_q  <= '0;
      pend_gain_q <= '0;
      act_sel_q   <= '0;
      act_gain_q  <= {D{GAIN_UNITY}};
      cfg_ack     <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_update) begin
            pend_sel_q  <= cfg_sel;
            pend_gain_q <= cfg_gain;
            state_q     <= PENDING;
          end
        end
        PENDING: begin
          if (adc_valid) begin
            act_sel_q  <= eff_sel;
            act_gain_q <= eff_gain;
            cfg_ack    <= 1'b1;
            state_q    <= IDLE;
          end else if (cfg_update) begin
            pend_sel_q  <= cfg_sel;
            pend_gain_q <= cfg_gain;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned d = 0; d < D; d++) begin
      if (reset) ramp_q[d] <= '0;
      else       ramp_q[d] <= ramp_next[d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      dac_valid <= 1'b0;
      dac_data  <= '0;
      sat_flag  <= '0;
    end else begin
      v1_q      <= adc_valid;
      v2_q      <= v1_q;
      dac_valid <= v2_q;
      if (v2_q) dac_data <= out_d;
      sat_flag  <= (sat_flag & ~{D{sat_clear}}) | (v2_q ? clip_d : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (adc_valid) begin
      for (int unsigned k = 0; k < N; k++) lane1_q[k] <= adc_data[k*SW +: SW];
      for (int unsigned d = 0; d < D; d++) begin
        sel1_q[d]  <= sel_e'(eff_sel[2*d +: 2]);
        gain1_q[d] <= eff_gain[d*GW +: GW];
        for (int unsigned k = 0; k < N; k++) ramp1_q[d][k] <= ramp_base[d] + SW'(k);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N; k++) trunc_d[k] = W_T'($signed(lane1_q[k]) >>> DROP_LSB);
    for (int unsigned d = 0; d < D; d++)
      for (int unsigned k = 0; k < N; k++)
        prod_d[d][k] = W_P'(trunc_d[k]) * W_P'($signed({1'b0, gain1_q[d]}));
  end

  always_ff @(posedge clock) begin
    if (v1_q) begin
      lane2_q <= lane1_q;
      sel2_q  <= sel1_q;
      ramp2_q <= ramp1_q;
      prod2_q <= prod_d;
    end
  end

  always_comb begin
    out_d  = '0;
    clip_d = '0;
    for (int unsigned d = 0; d < D; d++) begin
      for (int unsigned k = 0; k < N; k++) begin
        scaled_d[d][k] = (W_Q'(prod2_q[d][k]) >>> (GW - 1)) <<< DROP_LSB;
        case (sel2_q[d])
          SEL_ZERO: out_d[(d*N + k)*SW +: SW] = '0;
          SEL_PASS: out_d[(d*N + k)*SW +: SW] = lane2_q[k];
          SEL_RAMP: out_d[(d*N + k)*SW +: SW] = ramp2_q[d][k];
          SEL_SCALE: begin
            if (scaled_d[d][k] > SAT_MAX) begin
              out_d[(d*N + k)*SW +: SW] = SAT_MAX[SW-1:0];
              clip_d[d] = 1'b1;
            end else if (scaled_d[d][k] < SAT_MIN) begin
              out_d[(d*N + k)*SW +: SW] = SAT_MIN[SW-1:0];
              clip_d[d] = 1'b1;
            end else begin
              out_d[(d*N + k)*SW +: SW] = scaled_d[d][k][SW-1:0];
            end
          end
          default: out_d[(d*N + k)*SW +: SW] = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_lane_router.sv
// Randomised scoreboard bench for rx_lane_router against a cycle-level reference of the routing rules.
module tb_rx_lane_router;

  localparam int N    = 8;
  localparam int SW   = 16;
  localparam int DROP = 2;
  localparam int D    = 3;
  localparam int GW   = 8;
  localparam int LW   = SW * N;
  localparam int OW   = LW * D;
  localparam int MAXE = 40000;

  logic              clock = 1'b0;
  logic              reset;
  logic [LW-1:0]     adc_data;
  logic              adc_valid;
  logic [2*D-1:0]    cfg_sel;
  logic [GW*D-1:0]   cfg_gain;
  logic              cfg_update;
  logic              cfg_ack;
  logic [OW-1:0]     dac_data;
  logic              dac_valid;
  logic [D-1:0]      sat_flag;
  logic              sat_clear;

  rx_lane_router #(
    .NUMBER_OF_LINE(N),
    .SAMPLE_WIDTH(SW),
    .DROP_LSB(DROP),
    .NUMBER_OF_DAC(D),
    .GAIN_WIDTH(GW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .cfg_sel(cfg_sel),
    .cfg_gain(cfg_gain),
    .cfg_update(cfg_update),
    .cfg_ack(cfg_ack),
    .dac_data(dac_data),
    .dac_valid(dac_valid),
    .sat_flag(sat_flag),
    .sat_clear(sat_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            edge_n;
    logic [OW-1:0] data;
    logic [D-1:0]  clip;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_exp [MAXE];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  bit   rst_s    = 1'b1;
  bit   clr_s    = 1'b0;

  // Reference state: what the router should hold, in specification terms.
  bit   m_pending;
  int   m_psel [D];
  int   m_pgain[D];
  int   m_asel [D];
  int   m_again[D];
  int   m_ramp [D];

  always @(posedge clock) begin
    edge_n++;
    rst_s = reset;
    clr_s = sat_clear;
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int scale(input int lane, input int gain, output bit clip);
    longint x, q;
    x = (lane >= 32768) ? longint'(lane) - 65536 : longint'(lane);
    q = fdiv(fdiv(x, 1 << DROP) * gain, 1 << (GW - 1)) * (1 << DROP);
    clip = 1'b0;
    if (q > 32767)  begin q = 32767;  clip = 1'b1; end
    if (q < -32768) begin q = -32768; clip = 1'b1; end
    return int'(q) & 16'hFFFF;
  endfunction

  task automatic cycle(input bit v, input logic [LW-1:0] data, input bit upd,
                       input logic [2*D-1:0] sel, input logic [GW*D-1:0] gain,
                       input bit clr, input bit rst);
    int   e;
    bit   app, c;
    exp_t ent;
    int   lane, o;
    e          = edge_n;
    reset      = rst;
    adc_valid  = v;
    adc_data   = data;
    cfg_update = upd;
    cfg_sel    = sel;
    cfg_gain   = gain;
    sat_clear  = clr;
    if (rst) begin
      m_pending = 1'b0;
      for (int d = 0; d < D; d++) begin
        m_asel[d] = 0; m_again[d] = 128; m_ramp[d] = 0;
      end
    end else begin
      app = m_pending && v;
      if (app) begin
        for (int d = 0; d < D; d++) begin
          m_asel[d]  = upd ? int'(sel[2*d +: 2])    : m_psel[d];
          m_again[d] = upd ? int'(gain[GW*d +: GW]) : m_pgain[d];
          m_ramp[d]  = 0;
        end
        m_pending = 1'b0;
        if (e + 1 < MAXE) ack_exp[e + 1] = 1'b1;
      end else if (upd) begin
        for (int d = 0; d < D; d++) begin
          m_psel[d]  = int'(sel[2*d +: 2]);
          m_pgain[d] = int'(gain[GW*d +: GW]);
        end
        m_pending = 1'b1;
      end
      if (v) begin
        ent.edge_n = e + 3;
        ent.data   = '0;
        ent.clip   = '0;
        for (int d = 0; d < D; d++) begin
          for (int k = 0; k < N; k++) begin
            lane = int'(data[k*SW +: SW]);
            case (m_asel[d])
              1:       o = lane;
              2:       begin o = scale(lane, m_again[d], c); if (c) ent.clip[d] = 1'b1; end
              3:       o = (m_ramp[d] + k) % 65536;
              default: o = 0;
            endcase
            ent.data[(d*N + k)*SW +: SW] = SW'(o);
          end
          if (m_asel[d] == 3) m_ramp[d] = (m_ramp[d] + N) % 65536;
        end
        exp_q.push_back(ent);
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle, pair the DUT output with the oldest due scoreboard entry.
  logic [OW-1:0] last_data = '0;
  logic [D-1:0]  m_flag    = '0;
  initial begin
    exp_t e;
    bit   exp_v;
    int   en;
    forever begin
      @(negedge clock);
      en = edge_n;
      if (en == 0) continue;
      if (rst_s) begin
        chk("rst_valid", OW'(dac_valid), '0);
        chk("rst_data",  dac_data, '0);
        chk("rst_sat",   OW'(sat_flag), '0);
        chk("rst_ack",   OW'(cfg_ack), '0);
        m_flag    = '0;
        last_data = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_n < en) begin
          e = exp_q.pop_front();
          chk("lost_beat", OW'(e.edge_n), OW'(en));
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0].edge_n == en);
        chk("dac_valid", OW'(dac_valid), OW'(exp_v));
        if (exp_v) begin
          e = exp_q.pop_front();
          chk("dac_data", dac_data, e.data);
          last_data = e.data;
          m_flag = (m_flag & ~{D{clr_s}}) | e.clip;
        end else begin
          chk("hold_data", dac_data, last_data);
          m_flag = m_flag & ~{D{clr_s}};
        end
        chk("sat_flag", OW'(sat_flag), OW'(m_flag));
        chk("cfg_ack", OW'(cfg_ack), OW'((en < MAXE) ? ack_exp[en] : 1'b0));
      end
    end
  end

  initial begin
    logic [2*D-1:0]  sel;
    logic [GW*D-1:0] gain;
    logic [LW-1:0]   rnd;
    int              beats;
    bit              v;
    sel  = '0;
    gain = {D{8'h80}};
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, sel, gain, 0, 1);

    for (int i = 0; i < 4; i++) begin
      cycle(1, {N{16'h1234}}, 0, sel, gain, 0, 0);
      cycle(0, '0, 0, sel, gain, 0, 0);
    end

    sel = 6'b00_00_01;
    cycle(0, '0, 1, sel, gain, 0, 0);
    cycle(1, {N{16'h8001}}, 0, sel, gain, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 0, sel, gain, 0, 0);

    sel  = 6'b00_10_01;
    gain = {8'h80, 8'h80, 8'h80};
    cycle(0, '0, 1, sel, gain, 0, 0);
    cycle(1, {N{16'h1234}}, 0, sel, gain, 0, 0);
    gain = {8'h80, 8'h40, 8'h80};
    cycle(0, '0, 1, sel, gain, 0, 0);
    cycle(1, {N{16'h1234}}, 0, sel, gain, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 0, sel, gain, 0, 0);

    gain = {8'h80, 8'hFF, 8'h80};
    cycle(0, '0, 1, sel, gain, 0, 0);
    cycle(1, {(N/2){16'h8000, 16'h7FFC}}, 0, sel, gain, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 0, sel, gain, 0, 0);
    cycle(0, '0, 0, sel, gain, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, sel, gain, 0, 0);

    sel  = 6'b11_01_10;
    gain = {8'h80, 8'h80, 8'($urandom_range(0, 255))};
    cycle(0, '0, 1, sel, gain, 0, 0);
    beats = 0;
    while (beats < 8192) begin
      v   = ($urandom_range(0, 3) != 0);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(v, rnd, 0, sel, gain, ($urandom_range(0, 15) == 0), 0);
      if (v) beats++;
    end
    for (int i = 0; i < 3; i++) cycle(1, {N{16'h0101}}, 0, sel, gain, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 31) == 0) begin
        sel  = 6'($urandom);
        gain = 24'($urandom);
        cycle(v, rnd, 1, sel, gain, ($urandom_range(0, 7) == 0), 0);
      end else begin
        cycle(v, rnd, 0, sel, gain, ($urandom_range(0, 7) == 0), 0);
      end
    end

    for (int i = 0; i < 6; i++) cycle(0, '0, 0, sel, gain, 0, 0);
    cycle(0, '0, 1, 6'b01_01_01, {3{8'h20}}, 0, 0);
    cycle(0, '0, 1, 6'b10_11_01, {3{8'hC0}}, 0, 0);
    cycle(0, '0, 0, sel, gain, 0, 0);
    cycle(0, '0, 0, sel, gain, 0, 1);
    cycle(0, '0, 0, sel, gain, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, {N{16'h4321}}, 0, sel, gain, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, '0, 0, sel, gain, 0, 0);

    chk("drain", OW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
